cmd_feeder: RTL and testbench

CMD_FEEDER -- requirements
Module: cmd_feeder

---
 rtl/cmd_feeder.sv | 227 ++++++++++++++++++++++
 tb/tb_cmd_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_feeder.sv
// rtl/cmd_feeder.sv - host command frame feeder with argument FIFO and response framer
module cmd_feeder #(
  parameter int CMD_BITS  = 8,
  parameter int ARG_DEPTH = 8,
  parameter int RSP_DEPTH = 8,
  parameter int TIMEOUT   = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [CMD_BITS-1:0] cmd,
  output logic                cmd_ready,
  output logic [31:0]         arg_data,
  input  logic                arg_advance,
  input  logic                cmd_done,
  input  logic [31:0]         param_data,
  input  logic                param_write,
  input  logic                invol_req,
  output logic                invol_grant,
  output logic [31:0]         out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                err_args,
  output logic                err_rsp,
  output logic                err_timeout,
  input  logic                err_clr
);

  localparam int AW  = (ARG_DEPTH > 1) ? $clog2(ARG_DEPTH) : 1;
  localparam int ACW = $clog2(ARG_DEPTH + 1);
  localparam int RW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int RCW = $clog2(RSP_DEPTH + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_EXEC, S_RESP} state_t;

  state_t         state;
  logic           started;
  logic           partial;
  logic           drop;
  logic [TW-1:0]  tmo_cnt;
  logic [RCW-1:0] rd_idx;

  logic [31:0]    arg_mem [ARG_DEPTH];
  logic [AW-1:0]  arg_wr;
  logic [AW-1:0]  arg_rd;
  logic [ACW-1:0] arg_cnt;

  logic [31:0]    rsp_mem [RSP_DEPTH];
  logic [RCW-1:0] rsp_cnt;

  logic        grant_now;
  logic        accept;
  logic        arg_full;
  logic        arg_ovf;
  logic        arg_push;
  logic        arg_pop;
  logic        arg_flush;
  logic        exec_done;
  logic        exec_tmo;
  logic        rsp_wr;
  logic        rsp_push;
  logic        rsp_ovf;
  logic        rsp_flush;
  logic [31:0] header;

  function automatic logic [AW-1:0] arg_next(input logic [AW-1:0] p);
    return (p == AW'(ARG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake qualifiers, buffer strobes and the response header word
  always_comb begin
    grant_now = started && (state == S_LOAD) && !partial && invol_req;
    in_ready  = started && (state == S_LOAD) && !grant_now;
    accept    = in_valid && in_ready;
    arg_full  = (arg_cnt == ACW'(ARG_DEPTH));
    arg_ovf   = accept && partial && arg_full;
    arg_push  = accept && partial && !arg_full;
    arg_pop   = ((state == S_ISSUE) || (state == S_EXEC)) && arg_advance && (arg_cnt != '0);
    exec_done = (state == S_EXEC) && cmd_done;
    exec_tmo  = (state == S_EXEC) && !cmd_done && (tmo_cnt == TW'(TIMEOUT - 1));
    rsp_wr    = (state == S_EXEC) && param_write && !cmd_done && !exec_tmo;
    rsp_push  = rsp_wr && (rsp_cnt != RCW'(RSP_DEPTH));
    rsp_ovf   = rsp_wr && (rsp_cnt == RCW'(RSP_DEPTH));
    arg_flush = (accept && partial && in_last && (drop || arg_ovf)) || exec_done || exec_tmo;
    rsp_flush = exec_tmo || ((state == S_RESP) && out_ready && out_last);
    arg_data  = (arg_cnt != '0) ? arg_mem[arg_rd] : '0;
    header                 = '0;
    header[15:8]           = 8'(rsp_cnt);
    header[CMD_BITS-1:0]   = param_data[CMD_BITS-1:0];
  end

  // Argument and response storage (no reset: occupancy counters gate every read)
  always_ff @(posedge clk) begin
    if (arg_push) arg_mem[arg_wr] <= in_data;
    if (rsp_push) rsp_mem[rsp_cnt[RW-1:0]] <= param_data;
  end

  // Argument FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arg_wr  <= '0;
      arg_rd  <= '0;
      arg_cnt <= '0;
    end else if (arg_flush) begin
      arg_wr  <= '0;
      arg_rd  <= '0;
      arg_cnt <= '0;
    end else begin
      if (arg_push) arg_wr <= arg_next(arg_wr);
      if (arg_pop)  arg_rd <= arg_next(arg_rd);
      if (arg_push && !arg_pop)      arg_cnt <= arg_cnt + 1'b1;
      else if (arg_pop && !arg_push) arg_cnt <= arg_cnt - 1'b1;
    end
  end

  // Response buffer fill level; emptied on timeout or after the last word leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rsp_cnt <= '0;
    else if (rsp_flush) rsp_cnt <= '0;
    else if (rsp_push)  rsp_cnt <= rsp_cnt + 1'b1;
  end

  // Sticky error flags; a set wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_args    <= 1'b0;
      err_rsp     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_args    <= arg_ovf  ? 1'b1 : (err_clr ? 1'b0 : err_args);
      err_rsp     <= rsp_ovf  ? 1'b1 : (err_clr ? 1'b0 : err_rsp);
      err_timeout <= exec_tmo ? 1'b1 : (err_clr ? 1'b0 : err_timeout);
    end
  end

  // Main sequencer: load frame, issue, execute with timeout, emit response frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LOAD;
      started     <= 1'b0;
      partial     <= 1'b0;
      drop        <= 1'b0;
      cmd         <= '0;
      cmd_ready   <= 1'b0;
      invol_grant <= 1'b0;
      tmo_cnt     <= '0;
      rd_idx      <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      started     <= 1'b1;
      cmd_ready   <= 1'b0;
      invol_grant <= 1'b0;
      case (state)
        S_LOAD: begin
          if (grant_now) begin
            invol_grant <= 1'b1;
            tmo_cnt     <= '0;
            state       <= S_EXEC;
          end else if (accept) begin
            if (!partial) begin
              cmd <= in_data[CMD_BITS-1:0];
              if (in_last) begin
                state     <= S_ISSUE;
                cmd_ready <= 1'b1;
              end else begin
                partial <= 1'b1;
              end
            end else if (in_last) begin
              partial <= 1'b0;
              drop    <= 1'b0;
              if (!(drop || arg_ovf)) begin
                state     <= S_ISSUE;
                cmd_ready <= 1'b1;
              end
            end else if (arg_ovf) begin
              drop <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          if (cmd_done) begin
            if (rsp_cnt != '0) begin
              out_valid <= 1'b1;
              out_data  <= header;
              out_last  <= 1'b0;
              rd_idx    <= '0;
              state     <= S_RESP;
            end else begin
              state <= S_LOAD;
            end
          end else if (exec_tmo) begin
            state <= S_LOAD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              state     <= S_LOAD;
            end else begin
              out_data <= rsp_mem[rd_idx[RW-1:0]];
              out_last <= (rd_idx + 1'b1 == rsp_cnt);
              rd_idx   <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_feeder.sv
// tb/tb_cmd_feeder.sv - directed self-checking bench for cmd_feeder
module tb_cmd_feeder;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  cmd;
  logic        cmd_ready;
  logic [31:0] arg_data;
  logic        arg_advance;
  logic        cmd_done;
  logic [31:0] param_data;
  logic        param_write;
  logic        invol_req;
  logic        invol_grant;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        err_args;
  logic        err_rsp;
  logic        err_timeout;
  logic        err_clr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] fw [16];

  cmd_feeder #(.CMD_BITS(8), .ARG_DEPTH(8), .RSP_DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cmd(cmd), .cmd_ready(cmd_ready),
    .arg_data(arg_data), .arg_advance(arg_advance),
    .cmd_done(cmd_done), .param_data(param_data), .param_write(param_write),
    .invol_req(invol_req), .invol_grant(invol_grant),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .err_args(err_args), .err_rsp(err_rsp), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = fw[i];
      in_last  = (i == n - 1);
      #1;
      chk("in_ready_frame", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    arg_advance = 1'b0; cmd_done = 1'b0; param_data = '0; param_write = 1'b0;
    invol_req = 1'b0; out_ready = 1'b0; err_clr = 1'b0;

    // reset state
    #1;
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_arg_data", arg_data, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_errs", 32'({err_args, err_rsp, err_timeout}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    step(); #1;
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // 5-word frame, unit pops one argument per cycle
    fw[0] = 32'h05; fw[1] = 32'd3; fw[2] = 32'h100; fw[3] = 32'd7; fw[4] = 32'd2;
    send_frame(5);
    arg_advance = 1'b1;
    #1;
    chk("a_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("a_cmd", 32'(cmd), 32'h05);
    chk("a_arg0", arg_data, 32'd3);
    step(); #1;
    chk("a_cmd_ready_pulse", 32'(cmd_ready), 32'd0);
    chk("a_arg1", arg_data, 32'h100);
    step(); #1; chk("a_arg2", arg_data, 32'd7);
    step(); #1; chk("a_arg3", arg_data, 32'd2);
    step(); #1; chk("a_arg_empty", arg_data, 32'd0);
    step(); #1; chk("a_pop_empty", arg_data, 32'd0);
    arg_advance = 1'b0;

    // two response words, then completion code 0x0B; host stalls first
    param_write = 1'b1; param_data = 32'd2; step();
    param_data = 32'h1234; step();
    param_write = 1'b0; cmd_done = 1'b1; param_data = 32'h0B; step();
    cmd_done = 1'b0; param_data = '0;
    #1;
    chk("b_hdr_valid", 32'(out_valid), 32'd1);
    chk("b_hdr", out_data, 32'h0000020B);
    chk("b_hdr_last", 32'(out_last), 32'd0);
    step(); step(); #1;
    chk("b_stall_data", out_data, 32'h0000020B);
    chk("b_stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step(); #1;
    chk("b_w1", out_data, 32'd2);
    chk("b_w1_last", 32'(out_last), 32'd0);
    step(); #1;
    chk("b_w2", out_data, 32'h1234);
    chk("b_w2_last", 32'(out_last), 32'd1);
    step(); #1;
    chk("b_done_valid", 32'(out_valid), 32'd0);
    chk("b_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // one-word frame, completion without response words
    fw[0] = 32'h22;
    send_frame(1);
    #1;
    chk("c_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("c_arg_none", arg_data, 32'd0);
    step();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    #1;
    chk("c_no_out", 32'(out_valid), 32'd0);
    chk("c_in_ready", 32'(in_ready), 32'd1);

    // 9 arguments overflow the FIFO: frame dropped
    fw[0] = 32'h33;
    for (int i = 1; i <= 9; i++) fw[i] = 32'h100 + 32'(i);
    send_frame(10);
    #1;
    chk("d_err_args", 32'(err_args), 32'd1);
    chk("d_no_issue", 32'(cmd_ready), 32'd0);
    step(); #1;
    chk("d_still_load", 32'(in_ready), 32'd1);
    chk("d_fifo_flushed", arg_data, 32'd0);
    fw[0] = 32'h44; fw[1] = 32'hAA;
    send_frame(2);
    #1;
    chk("d_next_issue", 32'(cmd_ready), 32'd1);
    chk("d_next_cmd", 32'(cmd), 32'h44);
    chk("d_next_arg", arg_data, 32'hAA);
    step();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    #1 chk("d_err_clr", 32'(err_args), 32'd0);

    // involuntary request colliding with a new host frame
    invol_req = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1;
    #1 chk("e_in_ready_low", 32'(in_ready), 32'd0);
    step(); #1;
    chk("e_grant", 32'(invol_grant), 32'd1);
    chk("e_cmd_kept", 32'(cmd), 32'h44);
    chk("e_no_cmd_ready", 32'(cmd_ready), 32'd0);
    invol_req = 1'b0;
    param_write = 1'b1; param_data = 32'h11; step();
    #1 chk("e_grant_pulse", 32'(invol_grant), 32'd0);
    param_data = 32'h22; step();
    param_data = 32'h33; step();
    param_write = 1'b0; cmd_done = 1'b1; param_data = 32'h0C; step();
    cmd_done = 1'b0; param_data = '0; out_ready = 1'b1;
    #1;
    chk("e_hdr", out_data, 32'h0000030C);
    step(); #1; chk("e_w1", out_data, 32'h11);
    step(); #1; chk("e_w2", out_data, 32'h22);
    step(); #1; chk("e_w3", out_data, 32'h33); chk("e_w3_last", 32'(out_last), 32'd1);
    step(); #1;
    chk("e_resp_done", 32'(out_valid), 32'd0);
    chk("e_pending_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #1;
    chk("e_pending_issue", 32'(cmd_ready), 32'd1);
    chk("e_pending_cmd", 32'(cmd), 32'h55);

    // unit never completes: timeout after 16 cycles in S_EXEC
    for (int i = 0; i < 16; i++) begin
      param_write = (i == 1 || i == 2);
      param_data  = 32'hDEAD;
      step();
    end
    param_write = 1'b0;
    #1;
    chk("f_no_tmo_yet", 32'(err_timeout), 32'd0);
    chk("f_busy", 32'(in_ready), 32'd0);
    step(); #1;
    chk("f_tmo", 32'(err_timeout), 32'd1);
    chk("f_load", 32'(in_ready), 32'd1);
    chk("f_no_out", 32'(out_valid), 32'd0);
    fw[0] = 32'h66;
    send_frame(1);
    step();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    #1 chk("f_rsp_flushed", 32'(out_valid), 32'd0);

    // response overflow; clear in the same cycle as the overflow set
    fw[0] = 32'h77;
    send_frame(1);
    step();
    for (int i = 0; i < 9; i++) begin
      param_write = 1'b1;
      param_data  = 32'(i + 1);
      err_clr     = (i == 8);
      step();
    end
    param_write = 1'b0; err_clr = 1'b0;
    #1;
    chk("g_err_rsp", 32'(err_rsp), 32'd1);
    chk("g_tmo_cleared", 32'(err_timeout), 32'd0);
    cmd_done = 1'b1; param_data = 32'h0D; step();
    cmd_done = 1'b0; param_data = '0; out_ready = 1'b1;
    #1 chk("g_hdr", out_data, 32'h0000080D);
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      chk("g_word", out_data, 32'(i + 1));
      chk("g_last", 32'(out_last), 32'(i == 7));
    end
    step(); #1;
    chk("g_done", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // reset in the middle of a response frame
    fw[0] = 32'h12;
    send_frame(1);
    step();
    param_write = 1'b1; param_data = 32'd5; step();
    param_write = 1'b0; cmd_done = 1'b1; param_data = 32'h01; step();
    cmd_done = 1'b0; param_data = '0;
    #1 chk("h_resp_active", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("h_rst_valid", 32'(out_valid), 32'd0);
    chk("h_rst_cmd", 32'(cmd), 32'd0);
    chk("h_rst_err", 32'(err_rsp), 32'd0);
    step();
    rst = 1'b0;
    step(); #1;
    chk("h_in_ready", 32'(in_ready), 32'd1);
    chk("h_no_partial", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
